seg_scan_decoder: RTL and testbench

Recovers displayed digits from the multiplexed, active-low seven-segment bus (`seg`, `an`, `dp`) driven by the stopwatch display path. It synchronises and filters the scan and decodes each lit position into BCD. It flags blanked digits, protocol errors and stalled scanning. It is used in the board self-check build and as the scoreboard front end in system benches.

---
 rtl/seg_scan_decoder.sv | 89 ++++++++
 tb/tb_seg_scan_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers BCD digits from a filtered, multiplexed active-low seven-segment scan bus
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    input  logic       dp,
    input  logic       err_clr,
    output logic [3:0] mt,
    output logic [3:0] mo,
    output logic [3:0] st,
    output logic [3:0] so,
    output logic [3:0] blank_mask,
    output logic [3:0] dp_mask,
    output logic       frame_valid,
    output logic       err_multi_an,
    output logic       err_timeout
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] ACC_AT = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [11:0]   s1, s2;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [3:0]    seen, seen_nxt, sel, dec;
    logic [3:0]    dig [4];
    logic [3:0]    an_w;
    logic [6:0]    seg_w;
    logic          dp_w, acc, one_hot, multi;
    assign {an_w, seg_w, dp_w} = s2;
    assign sel = ~an_w;
    assign acc = cnt == ACC_AT;
    assign one_hot = acc && $onehot(sel);
    assign multi = acc && !$onehot0(sel);
    assign seen_nxt = seen | (one_hot ? sel : 4'h0);
    assign {mt, mo, st, so} = {dig[3], dig[2], dig[1], dig[0]};
    always_comb begin
        case (seg_w)
            7'h40:   dec = 4'd0;
            7'h79:   dec = 4'd1;
            7'h24:   dec = 4'd2;
            7'h30:   dec = 4'd3;
            7'h19:   dec = 4'd4;
            7'h12:   dec = 4'd5;
            7'h02:   dec = 4'd6;
            7'h78:   dec = 4'd7;
            7'h00:   dec = 4'd8;
            7'h10:   dec = 4'd9;
            7'h7F:   dec = 4'hA;
            default: dec = 4'hE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= '1;
            s2           <= '1;
            cnt          <= '0;
            tcnt         <= '0;
            seen         <= '0;
            dig          <= '{default: 4'hA};
            blank_mask   <= 4'hF;
            dp_mask      <= 4'h0;
            frame_valid  <= 1'b0;
            err_multi_an <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            s1  <= {an, seg, dp};
            s2  <= s1;
            cnt <= s1 != s2 ? '0 : cnt == SAT ? cnt : cnt + 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (one_hot && sel[i]) begin
                    dig[i]        <= dec;
                    blank_mask[i] <= seg_w == 7'h7F;
                    dp_mask[i]    <= ~dp_w;
                end
            end
            frame_valid  <= seen_nxt == 4'hF;
            seen         <= seen_nxt == 4'hF ? 4'h0 : seen_nxt;
            tcnt         <= frame_valid || tcnt == T_LAST ? '0 : tcnt + 1'b1;
            err_timeout  <= (tcnt == T_LAST && !frame_valid) || (err_timeout && !err_clr);
            err_multi_an <= multi || (err_multi_an && !err_clr);
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized and directed checks of seg_scan_decoder against a behavioural scan model
module tb_seg_scan_decoder;
    localparam int S = 16;
    localparam int T = 1000;
    logic       clk = 0, rst_n = 0, dp = 1, err_clr = 0;
    logic [6:0] seg = 7'h7F;
    logic [3:0] an = 4'hF;
    logic [3:0] mt, mo, st, so, blank_mask, dp_mask;
    logic       frame_valid, err_multi_an, err_timeout;
    logic [3:0] dout [4];
    logic [3:0] exp_dig [4];
    logic [3:0] exp_blank, exp_dp, exp_seen;
    logic       exp_multi, fv_prev = 0;
    int         total = 0, bad = 0, fv_cnt = 0, exp_frames = 0;
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [26:0] rst_vec = {16'hAAAA, 4'hF, 4'h0, 3'b000};
    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .dp(dp), .err_clr(err_clr),
        .mt(mt), .mo(mo), .st(st), .so(so), .blank_mask(blank_mask), .dp_mask(dp_mask),
        .frame_valid(frame_valid), .err_multi_an(err_multi_an), .err_timeout(err_timeout)
    );
    assign dout[0] = so;
    assign dout[1] = st;
    assign dout[2] = mo;
    assign dout[3] = mt;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            fv_cnt++;
            total++;
            if (fv_prev) begin
                bad++;
                $display("FAIL fv_width: frame_valid high 2+ cycles, required 1");
            end
        end
        fv_prev = rst_n && frame_valid;
    end
    function automatic logic [3:0] ref_dec(input logic [6:0] s);
        if (s == 7'h7F) return 4'hA;
        for (int d = 0; d < 10; d++) if (tbl[d] == s) return 4'(d);
        return 4'hE;
    endfunction
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic model_reset();
        exp_dig = '{default: 4'hA};
        exp_blank = 4'hF;
        exp_dp = 4'h0;
        exp_seen = 4'h0;
        exp_multi = 0;
        exp_frames = 0;
    endtask
    task automatic do_reset();
        rst_n = 0;
        an = 4'hF;
        seg = 7'h7F;
        dp = 1;
        err_clr = 0;
        model_reset();
        step(2);
        rst_n = 1;
    endtask
    // a pattern held at the pins for n cycles is accepted iff n >= S
    task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an = a;
        seg = s;
        dp = d;
        step(n);
        if (n >= S && a != 4'hF) begin
            if ($onehot(~a)) begin
                for (int i = 0; i < 4; i++) begin
                    if (!a[i]) begin
                        exp_dig[i] = ref_dec(s);
                        exp_blank[i] = s == 7'h7F;
                        exp_dp[i] = ~d;
                        exp_seen[i] = 1;
                    end
                end
                if (exp_seen == 4'hF) begin
                    exp_frames++;
                    exp_seen = 0;
                end
            end else begin
                exp_multi = 1;
            end
        end
    endtask
    task automatic test_reset();
        step(2);
        total++;
        if ({mt, mo, st, so, blank_mask, dp_mask, frame_valid, err_multi_an, err_timeout} !== rst_vec) begin
            bad++;
            $display("FAIL reset_hold: got %h required %h", {mt, mo, st, so, blank_mask, dp_mask, frame_valid, err_multi_an, err_timeout}, rst_vec);
        end
        rst_n = 1;
        step(5);
        total++;
        if ({mt, mo, st, so, blank_mask, dp_mask, frame_valid, err_multi_an, err_timeout} !== rst_vec) begin
            bad++;
            $display("FAIL reset_idle: got %h required %h", {mt, mo, st, so, blank_mask, dp_mask, frame_valid, err_multi_an, err_timeout}, rst_vec);
        end
    endtask
    task automatic test_static();
        int f0;
        do_reset();
        f0 = fv_cnt;
        an = 4'hE;
        seg = 7'h30;
        step(S + 1);
        total++;
        if (so !== 4'hA) begin
            bad++;
            $display("FAIL static_early: so=%h required a", so);
        end
        step(1);
        total++;
        if (so !== 4'd3) begin
            bad++;
            $display("FAIL static_latency: so=%h required 3", so);
        end
        step(20 - S - 2);
        total++;
        if (fv_cnt !== f0 || so !== 4'd3) begin
            bad++;
            $display("FAIL static_hold: frames=%0d so=%h required %0d 3", fv_cnt - f0, so, 0);
        end
    endtask
    task automatic test_full_scan();
        int f0;
        logic [6:0] pat [4] = '{7'h12, 7'h40, 7'h79, 7'h24};
        do_reset();
        f0 = fv_cnt;
        for (int sc = 0; sc < 3; sc++) begin
            for (int p = 0; p < 4; p++) begin
                show(~(4'b1 << p), pat[p], 1, 200);
                if (p == 2) begin
                    total++;
                    if (fv_cnt !== f0 + sc) begin
                        bad++;
                        $display("FAIL scan_early_frame: frames=%0d required %0d", fv_cnt - f0, sc);
                    end
                end
                show(4'hF, 7'h7F, 1, 10);
            end
            total++;
            if ({mt, mo, st, so} !== 16'h2105 || blank_mask !== 4'h0 || dp_mask !== 4'h0) begin
                bad++;
                $display("FAIL scan_digits: got %h %h %h required 2105 0 0", {mt, mo, st, so}, blank_mask, dp_mask);
            end
            total++;
            if (fv_cnt !== f0 + sc + 1) begin
                bad++;
                $display("FAIL scan_frames: frames=%0d required %0d", fv_cnt - f0, sc + 1);
            end
        end
    endtask
    task automatic test_glitch();
        do_reset();
        an = 4'hE;
        seg = 7'h79;
        step(40);
        for (int c = 0; c < 48; c++) begin
            seg = (c < 8) ? 7'h00 : 7'h79;
            step(1);
            total++;
            if (so !== 4'd1) begin
                bad++;
                $display("FAIL glitch_so cycle %0d: so=%h required 1", c, so);
            end
        end
    endtask
    task automatic test_blank_invalid();
        do_reset();
        show(4'hB, 7'h40, 0, S + 4);
        total++;
        if (mo !== 4'd0 || blank_mask[2] !== 1'b0 || dp_mask[2] !== 1'b1) begin
            bad++;
            $display("FAIL mo_digit: mo=%h blank=%b dp=%b required 0 0 1", mo, blank_mask[2], dp_mask[2]);
        end
        show(4'hF, 7'h7F, 1, 5);
        show(4'hB, 7'h7F, 1, S + 4);
        total++;
        if (mo !== 4'hA || blank_mask[2] !== 1'b1 || dp_mask[2] !== 1'b0) begin
            bad++;
            $display("FAIL mo_blank: mo=%h blank=%b dp=%b required a 1 0", mo, blank_mask[2], dp_mask[2]);
        end
        show(4'hF, 7'h7F, 1, 5);
        show(4'h7, 7'h55, 1, S + 4);
        total++;
        if (mt !== 4'hE || blank_mask[3] !== 1'b0) begin
            bad++;
            $display("FAIL mt_invalid: mt=%h blank=%b required e 0", mt, blank_mask[3]);
        end
    endtask
    task automatic test_multi();
        do_reset();
        show(4'hE, 7'h19, 1, S + 4);
        show(4'hC, 7'h40, 1, S + 4);
        total++;
        if (err_multi_an !== 1'b1 || {mt, mo, st, so} !== 16'hAAA4) begin
            bad++;
            $display("FAIL multi_set: err=%b digits=%h required 1 aaa4", err_multi_an, {mt, mo, st, so});
        end
        err_clr = 1;
        step(1);
        err_clr = 0;
        total++;
        if (err_multi_an !== 1'b0) begin
            bad++;
            $display("FAIL multi_clear: err=%b required 0", err_multi_an);
        end
        an = 4'h3;
        seg = 7'h00;
        step(S + 1);
        total++;
        if (err_multi_an !== 1'b0) begin
            bad++;
            $display("FAIL multi_early: err=%b required 0", err_multi_an);
        end
        err_clr = 1;
        step(1);
        err_clr = 0;
        total++;
        if (err_multi_an !== 1'b1 || {mt, mo, st, so} !== 16'hAAA4) begin
            bad++;
            $display("FAIL multi_set_wins: err=%b digits=%h required 1 aaa4", err_multi_an, {mt, mo, st, so});
        end
    endtask
    task automatic test_timeout();
        int f0;
        do_reset();
        step(T - 1);
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: err=%b required 0", err_timeout);
        end
        step(1);
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_set: err=%b required 1", err_timeout);
        end
        show(4'hE, 7'h10, 0, S + 4);
        total++;
        if (so !== 4'd9 || dp_mask[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: so=%h dp=%b required 9 1", so, dp_mask[0]);
        end
        #3 rst_n = 0;
        #1;
        total++;
        if ({mt, mo, st, so, blank_mask, dp_mask, frame_valid, err_multi_an, err_timeout} !== rst_vec) begin
            bad++;
            $display("FAIL async_reset: got %h required %h", {mt, mo, st, so, blank_mask, dp_mask, frame_valid, err_multi_an, err_timeout}, rst_vec);
        end
        step(2);
        rst_n = 1;
        f0 = fv_cnt;
        for (int p = 1; p < 4; p++) begin
            show(~(4'b1 << p), tbl[p], 1, S + 4);
            show(4'hF, 7'h7F, 1, 6);
        end
        total++;
        if (fv_cnt !== f0) begin
            bad++;
            $display("FAIL reset_fresh_frame: frames=%0d required 0", fv_cnt - f0);
        end
        show(4'hE, tbl[0], 1, S + 4);
        show(4'hF, 7'h7F, 1, 6);
        total++;
        if (fv_cnt !== f0 + 1) begin
            bad++;
            $display("FAIL reset_frame_done: frames=%0d required 1", fv_cnt - f0);
        end
    endtask
    task automatic test_random();
        int f0, k, n;
        logic [3:0] a;
        logic [6:0] s;
        do_reset();
        f0 = fv_cnt;
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 7);
            a = ~(4'b1 << $urandom_range(0, 3));
            s = k < 5 ? tbl[$urandom_range(0, 9)] : k == 5 ? 7'h7F : 7'($urandom);
            if (k == 7) begin
                do a = 4'($urandom); while ($countones(~a) < 2);
            end
            n = $urandom_range(S - 4, S + 4);
            show(a, s, 1'($urandom), n);
            show(4'hF, 7'h7F, 1, $urandom_range(4, 7));
            for (int i = 0; i < 4; i++) begin
                total++;
                if (dout[i] !== exp_dig[i]) begin
                    bad++;
                    $display("FAIL rand_digit it=%0d pos=%0d: got %h required %h", it, i, dout[i], exp_dig[i]);
                end
            end
            total++;
            if (blank_mask !== exp_blank || dp_mask !== exp_dp || err_multi_an !== exp_multi) begin
                bad++;
                $display("FAIL rand_flags it=%0d: got %b %b %b required %b %b %b", it, blank_mask, dp_mask, err_multi_an, exp_blank, exp_dp, exp_multi);
            end
            total++;
            if (fv_cnt - f0 !== exp_frames) begin
                bad++;
                $display("FAIL rand_frames it=%0d: got %0d required %0d", it, fv_cnt - f0, exp_frames);
            end
        end
    endtask
    initial begin
        test_reset();
        test_static();
        test_full_scan();
        test_glitch();
        test_blank_invalid();
        test_multi();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
